oled_cmd_rx: RTL and testbench

- Display-side receiver for the OLED power/SPI init interface: the responder end of the init sequencer's sclk/sdin/vdd/vbat/res outputs.
- Oversamples sclk/sdin in the clk domain and assembles MSB-first command bytes.
- Decodes SSD1306 commands and their arguments, and tracks the power/reset sequence, flagging ordering violations.
- Serves as the on-board loopback checker and bench-side model for the init sequencer.

---
 rtl/oled_pkg.sv | 57 +++++
 rtl/oled_cmd_rx_if.sv | 21 ++
 rtl/oled_spi_shift_rx.sv | 104 ++++++++++
 rtl/oled_cmd_rx.sv | 187 ++++++++++++++++++
 tb/tb_oled_cmd_rx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: definitions shared by the OLED init sequencer and its display-side
// receiver (oled_cmd_rx).
//   - SSD1306 command bytes used during power-up
//   - the sequencer's init command list, so both ends agree on it
//   - power-sequence FSM states, decoder states and error codes
//   - takes_arg(): true for commands that are followed by one argument byte
package oled_pkg;

    localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] CMD_CONTRAST    = 8'h81;
    localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
    localparam logic [7:0] CMD_ADDR_MODE   = 8'h20;
    localparam logic [7:0] ARG_PUMP_ON     = 8'h14;

    // Init sequence sent by the sequencer. vbat is enabled just before
    // entry INIT_VBAT_IDX (the contrast command). The 8'h20 after COM_PINS
    // is that command's argument, not an addressing-mode command.
    localparam int INIT_LEN      = 12;
    localparam int INIT_VBAT_IDX = 5;
    localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
        CMD_DISP_OFF, CMD_CHARGE_PUMP, ARG_PUMP_ON, CMD_PRECHARGE, 8'hF1,
        CMD_CONTRAST, 8'h0F, 8'hA1, 8'hC8, CMD_COM_PINS, 8'h20, CMD_DISP_ON
    };

    typedef enum logic [2:0] {
        PWR_OFF  = 3'd0,
        VDD_UP   = 3'd1,
        IN_RESET = 3'd2,
        RES_DONE = 3'd3,
        VBAT_UP  = 3'd4,
        ACTIVE   = 3'd5
    } pwr_state_t;

    typedef enum logic {
        DEC_CMD = 1'b0,
        DEC_ARG = 1'b1
    } dec_state_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_VBAT_EARLY  = 3'd1,
        ERR_SHORT_RES   = 3'd2,
        ERR_EARLY_BYTE  = 3'd3,
        ERR_FRAMING     = 3'd4,
        ERR_DISP_UNSAFE = 3'd5
    } err_code_t;

    function automatic logic takes_arg(input logic [7:0] b);
        return (b == CMD_CHARGE_PUMP) || (b == CMD_CONTRAST) ||
               (b == CMD_PRECHARGE)   || (b == CMD_COM_PINS) ||
               (b == CMD_ADDR_MODE);
    endfunction

endpackage

// File: rtl/oled_cmd_rx_if.sv
// oled_cmd_rx_if: the OLED power / SPI init link between the init sequencer
// (master) and the display or its loopback checker (slave).
//   sclk  serial clock, idles low; sdin is sampled on its rising edge
//   sdin  serial data, MSB first, changed while sclk is low
//   vdd   logic supply enable, active-low
//   vbat  panel supply enable, active-low
//   res   display reset, active-low
// Protocol: there is no valid/ready handshake; the master owns every signal
// and the slave only observes. A byte is eight sclk rising edges; the slave
// cannot back-pressure, so it must keep up with any sclk slower than
// clk / (2 * (SYNC_STAGES + 1)).
interface oled_cmd_rx_if;
    logic sclk;
    logic sdin;
    logic vdd;
    logic vbat;
    logic res;

    modport master (output sclk, sdin, vdd, vbat, res);
    modport slave  (input  sclk, sdin, vdd, vbat, res);
endinterface

// File: rtl/oled_spi_shift_rx.sv
// oled_spi_shift_rx: input conditioning and byte assembly for oled_cmd_rx.
// Ports:
//   clk, rst              system clock, async active-high reset
//   sclk, sdin, vdd,      raw asynchronous link inputs
//   vbat, res
//   vdd_s, vbat_s, res_s  synchronized supply/reset levels
//   byte_valid            one-cycle strobe, cycle after the 8th sclk edge
//   byte_data             last completed byte, held
//   frame_err             one-cycle strobe when a partial byte times out
module oled_spi_shift_rx #(
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_CLKS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       vdd,
    input  logic       vbat,
    input  logic       res,
    output logic       vdd_s,
    output logic       vbat_s,
    output logic       res_s,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);

    // Bit order {vdd, vbat, res, sdin, sclk}. Supplies and reset come out
    // of reset at their inactive (high) level so the power FSM does not see
    // a false power-up while the chain fills.
    localparam logic [4:0] SYNC_RST = 5'b11100;

    logic [4:0]        sync_q [SYNC_STAGES];
    logic [4:0]        sync_out;
    logic              sclk_s;
    logic              sdin_s;
    logic              sclk_d;
    logic              sclk_rise;
    logic [6:0]        shift_q;
    logic [2:0]        bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {vdd, vbat, res, sdin, sclk};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // sdin goes through the same depth as sclk, so the synchronized data
    // bit is the one that was stable around the raw sclk rise.
    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign sclk_s    = sync_out[0];
    assign sdin_s    = sync_out[1];
    assign res_s     = sync_out[2];
    assign vbat_s    = sync_out[3];
    assign vdd_s     = sync_out[4];
    assign sclk_rise = sclk_s & ~sclk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d     <= 1'b0;
            shift_q    <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            sclk_d     <= sclk_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!res_s) begin
                // Reset wins over a byte completing in the same cycle.
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else if (sclk_rise) begin
                shift_q  <= {shift_q[5:0], sdin_s};
                bit_cnt  <= bit_cnt + 3'd1;
                idle_cnt <= '0;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift_q, sdin_s};
                end
            end else if (bit_cnt != 3'd0) begin
                if (idle_cnt == IDLE_W'(TIMEOUT_CLKS - 1)) begin
                    bit_cnt   <= '0;
                    idle_cnt  <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/oled_cmd_rx.sv
// oled_cmd_rx: display-side receiver and loopback checker for the OLED init
// sequencer. Assembles SPI command bytes, decodes the SSD1306 commands that
// matter for power-up and tracks the vdd/res/vbat ordering.
// Ports:
//   clk, rst     system clock, async active-high reset
//   bus          link from the sequencer (slave modport)
//   byte_valid   one-cycle strobe per completed byte
//   byte_data    last completed byte
//   cmd_count    completed bytes, saturating at 31
//   display_on   0xAF sets, 0xAE clears
//   pump_en      charge pump state from 0x8D argument bit 2
//   contrast     argument of 0x81 (0x7F after reset)
//   init_done    power FSM reached ACTIVE
//   seq_err      sticky error flag
//   err_code     first error cause (err_code_t), 0 = none
//   pwr_state    power FSM state, for observation
//   dec_state    decoder FSM state, for observation
module oled_cmd_rx
    import oled_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_CLKS = 1000,
    parameter int MIN_RES_CLKS = 100
) (
    input  logic         clk,
    input  logic         rst,
    oled_cmd_rx_if.slave bus,
    output logic         byte_valid,
    output logic [7:0]   byte_data,
    output logic [4:0]   cmd_count,
    output logic         display_on,
    output logic         pump_en,
    output logic [7:0]   contrast,
    output logic         init_done,
    output logic         seq_err,
    output logic [2:0]   err_code,
    output pwr_state_t   pwr_state,
    output dec_state_t   dec_state
);

    localparam int          RES_W       = $clog2(MIN_RES_CLKS + 1);
    localparam logic [7:0]  CONTRAST_RST = 8'h7F;

    logic             vdd_s, vbat_s, res_s, frame_err;
    dec_state_t       dec_next;
    pwr_state_t       pwr_next;
    logic [7:0]       pend_cmd, pend_next;
    logic             disp_next, pump_next, display_d;
    logic [7:0]       contrast_next;
    logic [RES_W-1:0] res_cnt, res_cnt_next;
    logic             af_unsafe, short_res, early_byte, vbat_early;
    err_code_t        err_q, err_new;

    oled_spi_shift_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .sclk      (bus.sclk),
        .sdin      (bus.sdin),
        .vdd       (bus.vdd),
        .vbat      (bus.vbat),
        .res       (bus.res),
        .vdd_s     (vdd_s),
        .vbat_s    (vbat_s),
        .res_s     (res_s),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // Command decoder: commands with an argument park in pend_cmd until
    // the next byte arrives.
    always_comb begin
        dec_next      = dec_state;
        pend_next     = pend_cmd;
        disp_next     = display_on;
        pump_next     = pump_en;
        contrast_next = contrast;
        af_unsafe     = 1'b0;
        if (!res_s) begin
            dec_next      = DEC_CMD;
            disp_next     = 1'b0;
            pump_next     = 1'b0;
            contrast_next = CONTRAST_RST;
        end else if (byte_valid) begin
            case (dec_state)
                DEC_CMD: begin
                    if (takes_arg(byte_data)) begin
                        pend_next = byte_data;
                        dec_next  = DEC_ARG;
                    end else if (byte_data == CMD_DISP_OFF) begin
                        disp_next = 1'b0;
                    end else if (byte_data == CMD_DISP_ON) begin
                        disp_next = 1'b1;
                        af_unsafe = !pump_en || vbat_s;
                    end
                end
                DEC_ARG: begin
                    if (pend_cmd == CMD_CHARGE_PUMP) pump_next = byte_data[2];
                    else if (pend_cmd == CMD_CONTRAST) contrast_next = byte_data;
                    dec_next = DEC_CMD;
                end
                default: dec_next = DEC_CMD;
            endcase
        end
    end

    // Power sequence. res_cnt holds the number of clk cycles res has been
    // low, saturating at MIN_RES_CLKS.
    always_comb begin
        pwr_next     = pwr_state;
        res_cnt_next = res_cnt;
        short_res    = 1'b0;
        if (vdd_s) begin
            pwr_next = PWR_OFF;
        end else begin
            case (pwr_state)
                PWR_OFF: pwr_next = VDD_UP;
                VDD_UP: begin
                    if (!res_s) begin
                        pwr_next     = IN_RESET;
                        res_cnt_next = RES_W'(1);
                    end
                end
                IN_RESET: begin
                    if (res_s) begin
                        pwr_next  = RES_DONE;
                        short_res = (res_cnt < RES_W'(MIN_RES_CLKS));
                    end else if (res_cnt < RES_W'(MIN_RES_CLKS)) begin
                        res_cnt_next = res_cnt + RES_W'(1);
                    end
                end
                RES_DONE: if (!vbat_s) pwr_next = VBAT_UP;
                VBAT_UP:  if (display_on && !display_d && pump_en) pwr_next = ACTIVE;
                ACTIVE:   pwr_next = ACTIVE;
                default:  pwr_next = PWR_OFF;
            endcase
        end
    end

    // Lower code wins when several errors fire together.
    always_comb begin
        vbat_early = !vbat_s && vdd_s;
        early_byte = byte_valid &&
                     ((pwr_state == PWR_OFF) || (pwr_state == VDD_UP) ||
                      (pwr_state == IN_RESET));
        err_new = ERR_NONE;
        if (vbat_early)      err_new = ERR_VBAT_EARLY;
        else if (short_res)  err_new = ERR_SHORT_RES;
        else if (early_byte) err_new = ERR_EARLY_BYTE;
        else if (frame_err)  err_new = ERR_FRAMING;
        else if (af_unsafe)  err_new = ERR_DISP_UNSAFE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_state  <= DEC_CMD;
            pend_cmd   <= '0;
            display_on <= 1'b0;
            pump_en    <= 1'b0;
            contrast   <= CONTRAST_RST;
            display_d  <= 1'b0;
            pwr_state  <= PWR_OFF;
            res_cnt    <= '0;
            err_q      <= ERR_NONE;
            cmd_count  <= '0;
        end else begin
            dec_state  <= dec_next;
            pend_cmd   <= pend_next;
            display_on <= disp_next;
            pump_en    <= pump_next;
            contrast   <= contrast_next;
            display_d  <= display_on;
            pwr_state  <= pwr_next;
            res_cnt    <= res_cnt_next;
            if (err_q == ERR_NONE) err_q <= err_new;
            if (byte_valid && (cmd_count != 5'd31)) cmd_count <= cmd_count + 5'd1;
        end
    end

    assign init_done = (pwr_state == ACTIVE);
    assign seq_err   = (err_q != ERR_NONE);
    assign err_code  = err_q;

endmodule

// File: tb/tb_oled_cmd_rx.sv
// tb_oled_cmd_rx: directed bench for oled_cmd_rx. Drives the link through the
// interface at sclk = clk/10 and checks outputs on the falling clk edge.
module tb_oled_cmd_rx;
    import oled_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic [4:0] cmd_count;
    logic       display_on, pump_en, init_done, seq_err;
    logic [7:0] contrast;
    logic [2:0] err_code;
    pwr_state_t pwr_state;
    dec_state_t dec_state;

    int checks = 0;
    int fails  = 0;
    int bv_seen = 0;

    oled_cmd_rx_if bus ();

    oled_cmd_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CLKS(1000),
        .MIN_RES_CLKS(100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .cmd_count (cmd_count),
        .display_on(display_on),
        .pump_en   (pump_en),
        .contrast  (contrast),
        .init_done (init_done),
        .seq_err   (seq_err),
        .err_code  (err_code),
        .pwr_state (pwr_state),
        .dec_state (dec_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (byte_valid) bv_seen++;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.sclk = 1'b0; bus.sdin = 1'b0;
        bus.vdd = 1'b1; bus.vbat = 1'b1; bus.res = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(SYNC_STAGES + 2);
    endtask

    // drivers
    task automatic send_bit(input logic b);
        bus.sclk = 1'b0; bus.sdin = b;
        wait_clks(HALF);
        bus.sclk = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        bus.sclk = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic power_to_res_done(input int low_clks);
        bus.vdd = 1'b0;
        wait_clks(5);
        bus.res = 1'b0;
        wait_clks(low_clks);
        bus.res = 1'b1;
        wait_clks(5);
    endtask

    task automatic run_init_sequence();
        power_to_res_done(200);
        for (int i = 0; i < INIT_VBAT_IDX; i++) send_byte(INIT_CMDS[i]);
        bus.vbat = 1'b0;
        wait_clks(5);
        for (int i = INIT_VBAT_IDX; i < INIT_LEN; i++) send_byte(INIT_CMDS[i]);
        wait_clks(5);
    endtask

    // tests
    task automatic test_reset();
        do_reset();
        checks++; if (byte_valid !== 1'b0) begin fails++; $display("FAIL reset_byte_valid: got %0b expected 0", byte_valid); end
        checks++; if (byte_data !== 8'h00) begin fails++; $display("FAIL reset_byte_data: got %h expected 00", byte_data); end
        checks++; if (cmd_count !== 5'd0) begin fails++; $display("FAIL reset_cmd_count: got %0d expected 0", cmd_count); end
        checks++; if (contrast !== 8'h7F) begin fails++; $display("FAIL reset_contrast: got %h expected 7f", contrast); end
        checks++; if ({display_on, pump_en, init_done, seq_err} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {display_on, pump_en, init_done, seq_err}); end
        checks++; if (err_code !== 3'd0) begin fails++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
        checks++; if (pwr_state !== PWR_OFF) begin fails++; $display("FAIL reset_pwr_state: got %0d expected %0d", pwr_state, PWR_OFF); end
        checks++; if (dec_state !== DEC_CMD) begin fails++; $display("FAIL reset_dec_state: got %0d expected %0d", dec_state, DEC_CMD); end
    endtask

    task automatic test_full_init();
        do_reset();
        run_init_sequence();
        checks++; if (pump_en !== 1'b1) begin fails++; $display("FAIL init_pump_en: got %0b expected 1", pump_en); end
        checks++; if (contrast !== 8'h0F) begin fails++; $display("FAIL init_contrast: got %h expected 0f", contrast); end
        checks++; if (display_on !== 1'b1) begin fails++; $display("FAIL init_display_on: got %0b expected 1", display_on); end
        checks++; if (init_done !== 1'b1) begin fails++; $display("FAIL init_done: got %0b expected 1", init_done); end
        checks++; if (cmd_count !== 5'd12) begin fails++; $display("FAIL init_cmd_count: got %0d expected 12", cmd_count); end
        checks++; if (seq_err !== 1'b0) begin fails++; $display("FAIL init_seq_err: got %0b expected 0", seq_err); end
        checks++; if (err_code !== 3'd0) begin fails++; $display("FAIL init_err_code: got %0d expected 0", err_code); end
        checks++; if (byte_data !== 8'hAF) begin fails++; $display("FAIL init_byte_data: got %h expected af", byte_data); end
    endtask

    task automatic test_byte_timing();
        logic [7:0] pat = 8'hA5;
        int         bv0;
        do_reset();
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        bus.sclk = 1'b0; bus.sdin = pat[0];
        wait_clks(HALF);
        bv0 = bv_seen;
        bus.sclk = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (byte_valid !== (k == SYNC_STAGES + 1)) begin
                fails++;
                $display("FAIL timing_byte_valid_clk%0d: got %0b expected %0b", k, byte_valid, (k == SYNC_STAGES + 1));
            end
            if (k == HALF) bus.sclk = 1'b0;
        end
        wait_clks(HALF);
        checks++; if (bv_seen - bv0 !== 1) begin fails++; $display("FAIL timing_pulse_count: got %0d expected 1", bv_seen - bv0); end
        checks++; if (byte_data !== 8'hA5) begin fails++; $display("FAIL timing_byte_data: got %h expected a5", byte_data); end
        checks++; if (cmd_count !== 5'd1) begin fails++; $display("FAIL timing_cmd_count: got %0d expected 1", cmd_count); end
        // byte arrived with power off
        checks++; if (err_code !== 3'd3) begin fails++; $display("FAIL timing_err_early_byte: got %0d expected 3", err_code); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus.sclk = 1'b0;
        wait_clks(900);
        checks++; if (err_code !== 3'd0) begin fails++; $display("FAIL timeout_not_early: got %0d expected 0", err_code); end
        wait_clks(200);
        checks++; if (err_code !== 3'd4) begin fails++; $display("FAIL timeout_err_code: got %0d expected 4", err_code); end
        checks++; if (seq_err !== 1'b1) begin fails++; $display("FAIL timeout_seq_err: got %0b expected 1", seq_err); end
        send_byte(8'h3C);
        checks++; if (byte_data !== 8'h3C) begin fails++; $display("FAIL timeout_realign: got %h expected 3c", byte_data); end
        checks++; if (err_code !== 3'd4) begin fails++; $display("FAIL timeout_first_wins: got %0d expected 4", err_code); end
    endtask

    task automatic test_power_errors();
        do_reset();
        power_to_res_done(50);
        checks++; if (err_code !== 3'd2) begin fails++; $display("FAIL short_res_err_code: got %0d expected 2", err_code); end
        checks++; if (pwr_state !== RES_DONE) begin fails++; $display("FAIL short_res_pwr_state: got %0d expected %0d", pwr_state, RES_DONE); end
        do_reset();
        bus.vbat = 1'b0;
        wait_clks(5);
        checks++; if (err_code !== 3'd1) begin fails++; $display("FAIL vbat_early_err_code: got %0d expected 1", err_code); end
        checks++; if (pwr_state !== PWR_OFF) begin fails++; $display("FAIL vbat_early_pwr_state: got %0d expected %0d", pwr_state, PWR_OFF); end
    endtask

    task automatic test_af_early();
        do_reset();
        power_to_res_done(200);
        bus.vbat = 1'b0;
        wait_clks(5);
        send_byte(CMD_DISP_ON);
        checks++; if (err_code !== 3'd5) begin fails++; $display("FAIL af_early_err_code: got %0d expected 5", err_code); end
        checks++; if (display_on !== 1'b1) begin fails++; $display("FAIL af_early_display_on: got %0b expected 1", display_on); end
        checks++; if (init_done !== 1'b0) begin fails++; $display("FAIL af_early_init_done: got %0b expected 0", init_done); end
    endtask

    task automatic test_res_mid();
        int bv0;
        do_reset();
        power_to_res_done(200);
        send_byte(CMD_CONTRAST);
        checks++; if (dec_state !== DEC_ARG) begin fails++; $display("FAIL resmid_dec_arg: got %0d expected %0d", dec_state, DEC_ARG); end
        bv0 = bv_seen;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        bus.sclk = 1'b0; bus.res = 1'b0;
        wait_clks(10);
        checks++; if (dec_state !== DEC_CMD) begin fails++; $display("FAIL resmid_dec_cmd: got %0d expected %0d", dec_state, DEC_CMD); end
        checks++; if (contrast !== 8'h7F) begin fails++; $display("FAIL resmid_contrast: got %h expected 7f", contrast); end
        checks++; if (bv_seen - bv0 !== 0) begin fails++; $display("FAIL resmid_no_pulse: got %0d expected 0", bv_seen - bv0); end
        bus.res = 1'b1;
        wait_clks(5);
        send_byte(8'h55);
        checks++; if (byte_data !== 8'h55) begin fails++; $display("FAIL resmid_realign: got %h expected 55", byte_data); end
        checks++; if (contrast !== 8'h7F) begin fails++; $display("FAIL resmid_not_arg: got %h expected 7f", contrast); end
        checks++; if (cmd_count !== 5'd2) begin fails++; $display("FAIL resmid_cmd_count: got %0d expected 2", cmd_count); end
        // 8th edge and res fall together: res wins
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        bus.sclk = 1'b0; bus.sdin = 1'b1;
        wait_clks(HALF);
        bv0 = bv_seen;
        bus.sclk = 1'b1; bus.res = 1'b0;
        wait_clks(10);
        bus.sclk = 1'b0;
        checks++; if (bv_seen - bv0 !== 0) begin fails++; $display("FAIL race_no_pulse: got %0d expected 0", bv_seen - bv0); end
        checks++; if (byte_data !== 8'h55) begin fails++; $display("FAIL race_byte_data: got %h expected 55", byte_data); end
        checks++; if (cmd_count !== 5'd2) begin fails++; $display("FAIL race_cmd_count: got %0d expected 2", cmd_count); end
        bus.res = 1'b1;
        wait_clks(5);
    endtask

    task automatic test_rst_mid();
        do_reset();
        run_init_sequence();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (cmd_count !== 5'd0) begin fails++; $display("FAIL rstmid_cmd_count: got %0d expected 0", cmd_count); end
        checks++; if (byte_data !== 8'h00) begin fails++; $display("FAIL rstmid_byte_data: got %h expected 00", byte_data); end
        checks++; if (contrast !== 8'h7F) begin fails++; $display("FAIL rstmid_contrast: got %h expected 7f", contrast); end
        checks++; if ({display_on, pump_en, init_done, seq_err, byte_valid} !== 5'b00000) begin fails++; $display("FAIL rstmid_flags: got %b expected 00000", {display_on, pump_en, init_done, seq_err, byte_valid}); end
        checks++; if (pwr_state !== PWR_OFF) begin fails++; $display("FAIL rstmid_pwr_state: got %0d expected %0d", pwr_state, PWR_OFF); end
        checks++; if (err_code !== 3'd0) begin fails++; $display("FAIL rstmid_err_code: got %0d expected 0", err_code); end
        do_reset();
        send_byte(8'hC3);
        checks++; if (byte_data !== 8'hC3) begin fails++; $display("FAIL rstmid_realign: got %h expected c3", byte_data); end
    endtask

    initial begin
        bus.sclk = 1'b0; bus.sdin = 1'b0;
        bus.vdd = 1'b1; bus.vbat = 1'b1; bus.res = 1'b1;
        test_reset();
        test_full_init();
        test_byte_timing();
        test_timeout();
        test_power_errors();
        test_af_early();
        test_res_mid();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
